// File: rtl/regfile_preloader_pkg.sv
// Shared definitions for the regfile preloader: FSM state encoding and register index width.
package regfile_preloader_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_LOAD    = 3'd2,
    S_DRAIN   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_preloader.sv
// Bring-up writer: holds the CPU in reset, clears the regfile, streams initial register
// values through the hijacked write port, then releases the CPU.
module regfile_preloader
  import regfile_preloader_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGS     = 32,
  parameter int FIRST_REG    = 1,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  rf_sel,
  output logic                  rf_we,
  output logic [REG_IDX_W-1:0]  rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_reset,
  output logic                  proc_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [REG_IDX_W-1:0] FIRST_IDX  = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX   = REG_IDX_W'(NUM_REGS - 1);

  state_t               state;
  logic [CNT_W-1:0]     clear_cnt;
  logic [REG_IDX_W-1:0] idx;
  logic                 handshake;

  assign handshake = in_valid & in_ready;

  // Single FSM block; every output is a register updated on the transition into its state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      clear_cnt  <= '0;
      idx        <= '0;
      in_ready   <= 1'b0;
      rf_sel     <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      rf_reset   <= 1'b0;
      proc_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_CLEAR;
            clear_cnt  <= '0;
            idx        <= FIRST_IDX;
            done       <= 1'b0;
            error      <= 1'b0;
            busy       <= 1'b1;
            rf_sel     <= 1'b1;
            rf_reset   <= 1'b1;
            proc_reset <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (clear_cnt == CLEAR_LAST) begin
            state    <= S_LOAD;
            rf_reset <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            clear_cnt <= clear_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            rf_we    <= 1'b1;
            rf_waddr <= idx;
            rf_wdata <= in_data;
            // Running out of registers closes the session; idx is left at the top, never wrapped.
            if (in_last || (idx == LAST_IDX)) begin
              state    <= S_DRAIN;
              in_ready <= 1'b0;
              error    <= ~in_last;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          state      <= S_RELEASE;
          rf_sel     <= 1'b0;
          proc_reset <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b1;
        end
        S_RELEASE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
